// File: rtl/e203_soc_lite.sv
// Reduced single-clock SoC: multicycle RV32I-subset hart on a 64-bit ITCM,
// M-mode traps/interrupts, one GPIO bank and an lfextclk-driven mtime counter.
module e203_soc_lite #(
  parameter int unsigned ITCM_DP   = 1024,
  parameter logic [31:0] RESET_PC  = 32'h8000_0000,
  parameter logic [31:0] MTVEC_RST = 32'h8000_0000
) (
  input  logic        hfextclk,
  input  logic        rst,
  input  logic        lfextclk,
  input  logic        ext_irq,
  input  logic        sft_irq,
  input  logic        tmr_irq,
  input  logic [31:0] gpioA_i_ival,
  output logic [31:0] gpioA_o_oval,
  output logic [31:0] gpioA_o_oe,
  output logic        jtag_tdo_oval,
  output logic        jtag_tdo_oe,
  output logic        cmt_valid,
  output logic [31:0] cmt_pc,
  output logic [31:0] x3_o
);

  localparam int unsigned AW         = $clog2(ITCM_DP);
  localparam logic [31:0] ITCM_BYTES = 32'(ITCM_DP * 8);
  localparam logic [31:0] GPIO_IN    = 32'h1001_2000;
  localparam logic [31:0] GPIO_OE    = 32'h1001_2004;
  localparam logic [31:0] GPIO_OVAL  = 32'h1001_2008;
  localparam logic [31:0] MTIME_ADDR = 32'h0200_BFF8;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYS    = 7'b1110011;

  typedef enum logic [1:0] {ST_FETCH = 2'd0, ST_EXEC = 2'd1, ST_MEM = 2'd2} state_t;

  function automatic logic itcm_hit(input logic [31:0] addr);
    return ((addr - RESET_PC) < ITCM_BYTES);
  endfunction

  state_t      state_r, next_state_s;
  logic [63:0] mem_r [0:ITCM_DP-1];
  logic [31:0] rf_r  [0:31];
  logic [31:0] pc_r, ir_r, mepc_r, mcause_r, mtvec_r, mtime_r;
  logic        mie_r, mpie_r;
  logic [31:0] oval_r, oe_r;
  logic        cmt_valid_r;
  logic [31:0] cmt_pc_r;
  logic        lf_sync1_r, lf_sync2_r, lf_prev_r;

  logic [6:0]  opc_s, f7_s;
  logic [4:0]  rd_s, rs1_s, rs2_s;
  logic [2:0]  f3_s;
  logic [11:0] csr_addr_s;
  logic [31:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s;
  logic [31:0] rs1_val_s, rs2_val_s, ls_addr_s, mem_addr_s, mem_rdata_s, fetch_word_s;
  logic [31:0] csr_rdata_s, csr_wdata_s, rd_wdata_s, pc_nxt_s, trap_cause_s, irq_cause_s;
  logic        csr_ok_s, csr_wen_s, rd_wen_s, commit_s, trap_s, mret_s, illegal_s, ir_load_s;
  logic        irq_pend_s, itcm_wen_s, oe_wen_s, oval_wen_s;
  logic [AW-1:0] fetch_idx_s, mem_idx_s;

  assign opc_s      = ir_r[6:0];
  assign rd_s       = ir_r[11:7];
  assign f3_s       = ir_r[14:12];
  assign rs1_s      = ir_r[19:15];
  assign rs2_s      = ir_r[24:20];
  assign f7_s       = ir_r[31:25];
  assign csr_addr_s = ir_r[31:20];
  assign imm_i_s    = {{20{ir_r[31]}}, ir_r[31:20]};
  assign imm_s_s    = {{20{ir_r[31]}}, ir_r[31:25], ir_r[11:7]};
  assign imm_b_s    = {{19{ir_r[31]}}, ir_r[31], ir_r[7], ir_r[30:25], ir_r[11:8], 1'b0};
  assign imm_u_s    = {ir_r[31:12], 12'd0};
  assign imm_j_s    = {{11{ir_r[31]}}, ir_r[31], ir_r[19:12], ir_r[20], ir_r[30:21], 1'b0};
  assign rs1_val_s  = (rs1_s == 5'd0) ? 32'd0 : rf_r[rs1_s];
  assign rs2_val_s  = (rs2_s == 5'd0) ? 32'd0 : rf_r[rs2_s];
  assign ls_addr_s  = rs1_val_s + ((opc_s == OP_STORE) ? imm_s_s : imm_i_s);
  assign mem_addr_s = ls_addr_s & 32'hFFFF_FFFC;
  assign fetch_idx_s = pc_r[AW+2:3];
  assign mem_idx_s   = mem_addr_s[AW+2:3];
  assign irq_pend_s  = mie_r & (ext_irq | sft_irq | tmr_irq);

  assign gpioA_o_oval  = oval_r;
  assign gpioA_o_oe    = oe_r;
  assign jtag_tdo_oval = 1'b0;
  assign jtag_tdo_oe   = 1'b0;
  assign cmt_valid     = cmt_valid_r;
  assign cmt_pc        = cmt_pc_r;
  assign x3_o          = rf_r[3];

  // Instruction fetch word and interrupt cause priority (ext > sft > tmr)
  always_comb begin
    fetch_word_s = 32'd0;
    irq_cause_s  = 32'h8000_0007;
    if (itcm_hit(pc_r)) begin
      fetch_word_s = pc_r[2] ? mem_r[fetch_idx_s][63:32] : mem_r[fetch_idx_s][31:0];
    end else begin
      fetch_word_s = 32'd0;
    end
    if (ext_irq) begin
      irq_cause_s = 32'h8000_000B;
    end else if (sft_irq) begin
      irq_cause_s = 32'h8000_0003;
    end else begin
      irq_cause_s = 32'h8000_0007;
    end
  end

  // Load data mux across ITCM and the peripheral registers
  always_comb begin
    mem_rdata_s = 32'd0;
    if (itcm_hit(mem_addr_s)) begin
      mem_rdata_s = mem_addr_s[2] ? mem_r[mem_idx_s][63:32] : mem_r[mem_idx_s][31:0];
    end else begin
      case (mem_addr_s)
        GPIO_IN:    mem_rdata_s = gpioA_i_ival;
        GPIO_OE:    mem_rdata_s = oe_r;
        GPIO_OVAL:  mem_rdata_s = oval_r;
        MTIME_ADDR: mem_rdata_s = mtime_r;
        default:    mem_rdata_s = 32'd0;
      endcase
    end
  end

  // CSR read port; unknown CSR addresses make the access illegal
  always_comb begin
    csr_ok_s    = 1'b1;
    csr_rdata_s = 32'd0;
    case (csr_addr_s)
      12'h300: csr_rdata_s = {24'd0, mpie_r, 3'd0, mie_r, 3'd0};
      12'h305: csr_rdata_s = mtvec_r;
      12'h341: csr_rdata_s = mepc_r;
      12'h342: csr_rdata_s = mcause_r;
      default: csr_ok_s = 1'b0;
    endcase
  end

  // Next-state, writeback and side-effect decode
  always_comb begin
    next_state_s = state_r;
    pc_nxt_s     = pc_r;
    rd_wen_s     = 1'b0;
    rd_wdata_s   = 32'd0;
    commit_s     = 1'b0;
    trap_s       = 1'b0;
    trap_cause_s = 32'd0;
    mret_s       = 1'b0;
    illegal_s    = 1'b0;
    csr_wen_s    = 1'b0;
    csr_wdata_s  = 32'd0;
    ir_load_s    = 1'b0;
    itcm_wen_s   = 1'b0;
    oe_wen_s     = 1'b0;
    oval_wen_s   = 1'b0;
    case (state_r)
      ST_FETCH: begin
        if (irq_pend_s) begin
          trap_s       = 1'b1;
          trap_cause_s = irq_cause_s;
        end else begin
          ir_load_s    = 1'b1;
          next_state_s = ST_EXEC;
        end
      end
      ST_EXEC: begin
        next_state_s = ST_FETCH;
        pc_nxt_s     = pc_r + 32'd4;
        commit_s     = 1'b1;
        case (opc_s)
          OP_LUI:   begin rd_wen_s = 1'b1; rd_wdata_s = imm_u_s; end
          OP_AUIPC: begin rd_wen_s = 1'b1; rd_wdata_s = pc_r + imm_u_s; end
          OP_JAL: begin
            rd_wen_s = 1'b1; rd_wdata_s = pc_r + 32'd4; pc_nxt_s = pc_r + imm_j_s;
          end
          OP_JALR: begin
            illegal_s  = (f3_s != 3'b000);
            rd_wen_s   = 1'b1;
            rd_wdata_s = pc_r + 32'd4;
            pc_nxt_s   = (rs1_val_s + imm_i_s) & 32'hFFFF_FFFE;
          end
          OP_BRANCH: begin
            case (f3_s)
              3'b000:  if (rs1_val_s == rs2_val_s) pc_nxt_s = pc_r + imm_b_s; else pc_nxt_s = pc_r + 32'd4;
              3'b001:  if (rs1_val_s != rs2_val_s) pc_nxt_s = pc_r + imm_b_s; else pc_nxt_s = pc_r + 32'd4;
              3'b100:  if ($signed(rs1_val_s) <  $signed(rs2_val_s)) pc_nxt_s = pc_r + imm_b_s; else pc_nxt_s = pc_r + 32'd4;
              3'b101:  if ($signed(rs1_val_s) >= $signed(rs2_val_s)) pc_nxt_s = pc_r + imm_b_s; else pc_nxt_s = pc_r + 32'd4;
              default: illegal_s = 1'b1;
            endcase
          end
          OP_LOAD, OP_STORE: begin
            illegal_s    = (f3_s != 3'b010);
            next_state_s = ST_MEM;
            pc_nxt_s     = pc_r;
            commit_s     = 1'b0;
          end
          OP_IMM: begin
            rd_wen_s = 1'b1;
            case (f3_s)
              3'b000:  rd_wdata_s = rs1_val_s + imm_i_s;
              3'b100:  rd_wdata_s = rs1_val_s ^ imm_i_s;
              3'b110:  rd_wdata_s = rs1_val_s | imm_i_s;
              3'b111:  rd_wdata_s = rs1_val_s & imm_i_s;
              3'b001:  begin illegal_s = (f7_s != 7'd0); rd_wdata_s = rs1_val_s << rs2_s; end
              3'b101:  begin illegal_s = (f7_s != 7'd0); rd_wdata_s = rs1_val_s >> rs2_s; end
              default: illegal_s = 1'b1;
            endcase
          end
          OP_REG: begin
            rd_wen_s = 1'b1;
            case ({f7_s, f3_s})
              10'b0000000_000: rd_wdata_s = rs1_val_s + rs2_val_s;
              10'b0100000_000: rd_wdata_s = rs1_val_s - rs2_val_s;
              10'b0000000_111: rd_wdata_s = rs1_val_s & rs2_val_s;
              10'b0000000_110: rd_wdata_s = rs1_val_s | rs2_val_s;
              10'b0000000_100: rd_wdata_s = rs1_val_s ^ rs2_val_s;
              default:         illegal_s  = 1'b1;
            endcase
          end
          OP_SYS: begin
            if (ir_r == 32'h3020_0073) begin
              mret_s   = 1'b1;
              pc_nxt_s = mepc_r;
            end else if (((f3_s == 3'b001) || (f3_s == 3'b010)) && csr_ok_s) begin
              rd_wen_s    = 1'b1;
              rd_wdata_s  = csr_rdata_s;
              csr_wen_s   = (f3_s == 3'b001) || (rs1_s != 5'd0);
              csr_wdata_s = (f3_s == 3'b001) ? rs1_val_s : (csr_rdata_s | rs1_val_s);
            end else begin
              illegal_s = 1'b1;
            end
          end
          default: illegal_s = 1'b1;
        endcase
        // An illegal encoding cancels every side effect decoded above
        if (illegal_s) begin
          trap_s       = 1'b1;
          trap_cause_s = 32'd2;
          next_state_s = ST_FETCH;
          commit_s     = 1'b0;
          rd_wen_s     = 1'b0;
          csr_wen_s    = 1'b0;
          mret_s       = 1'b0;
        end else begin
          trap_s = 1'b0;
        end
      end
      ST_MEM: begin
        next_state_s = ST_FETCH;
        pc_nxt_s     = pc_r + 32'd4;
        commit_s     = 1'b1;
        if (opc_s == OP_LOAD) begin
          rd_wen_s   = 1'b1;
          rd_wdata_s = mem_rdata_s;
        end else begin
          itcm_wen_s = itcm_hit(mem_addr_s);
          oe_wen_s   = (mem_addr_s == GPIO_OE);
          oval_wen_s = (mem_addr_s == GPIO_OVAL);
        end
      end
      default: next_state_s = ST_FETCH;
    endcase
  end

  // FSM state register
  always_ff @(posedge hfextclk) begin
    if (rst) state_r <= ST_FETCH;
    else     state_r <= next_state_s;
  end

  // Architectural state: pc, ir, register file, CSRs, GPIO and commit trace
  always_ff @(posedge hfextclk) begin
    if (rst) begin
      pc_r        <= RESET_PC;
      ir_r        <= 32'd0;
      for (int i = 0; i < 32; i++) rf_r[i] <= 32'd0;
      mie_r       <= 1'b0;
      mpie_r      <= 1'b0;
      mepc_r      <= 32'd0;
      mcause_r    <= 32'd0;
      mtvec_r     <= MTVEC_RST;
      oval_r      <= 32'd0;
      oe_r        <= 32'd0;
      cmt_valid_r <= 1'b0;
      cmt_pc_r    <= 32'd0;
    end else begin
      cmt_valid_r <= commit_s;
      if (commit_s) cmt_pc_r <= pc_r;
      if (ir_load_s) ir_r <= fetch_word_s;
      if (trap_s) begin
        mepc_r   <= pc_r;
        mcause_r <= trap_cause_s;
        mpie_r   <= mie_r;
        mie_r    <= 1'b0;
        pc_r     <= mtvec_r & 32'hFFFF_FFFC;
      end else if (mret_s) begin
        mie_r  <= mpie_r;
        mpie_r <= 1'b1;
        pc_r   <= pc_nxt_s;
      end else begin
        pc_r <= pc_nxt_s;
        if (csr_wen_s) begin
          case (csr_addr_s)
            12'h300: begin mie_r <= csr_wdata_s[3]; mpie_r <= csr_wdata_s[7]; end
            12'h305: mtvec_r  <= csr_wdata_s;
            12'h341: mepc_r   <= csr_wdata_s;
            12'h342: mcause_r <= csr_wdata_s;
            default: mtvec_r  <= mtvec_r;
          endcase
        end
      end
      if (rd_wen_s && (rd_s != 5'd0)) rf_r[rd_s] <= rd_wdata_s;
      if (oe_wen_s)   oe_r   <= rs2_val_s;
      if (oval_wen_s) oval_r <= rs2_val_s;
    end
  end

  // mtime: lfextclk is resynchronised and counted on each rising edge
  always_ff @(posedge hfextclk) begin
    if (rst) begin
      lf_sync1_r <= 1'b0;
      lf_sync2_r <= 1'b0;
      lf_prev_r  <= 1'b0;
      mtime_r    <= 32'd0;
    end else begin
      lf_sync1_r <= lfextclk;
      lf_sync2_r <= lf_sync1_r;
      lf_prev_r  <= lf_sync2_r;
      if (lf_sync2_r && !lf_prev_r) mtime_r <= mtime_r + 32'd1;
    end
  end

  // ITCM store port; contents survive reset so a preloaded image persists
  always @(posedge hfextclk) begin
    if (itcm_wen_s && !rst) begin
      if (mem_addr_s[2]) mem_r[mem_idx_s][63:32] <= rs2_val_s;
      else               mem_r[mem_idx_s][31:0]  <= rs2_val_s;
    end
  end

endmodule

// File: tb/tb_e203_soc_lite.sv
// Directed bench: preloads a small program into the ITCM and checks the commit
// trace, x3, CSR state and GPIO/mtime side effects against hand-computed values.
module tb_e203_soc_lite;

  logic        hfextclk = 1'b0;
  logic        rst, lfextclk, ext_irq, sft_irq, tmr_irq;
  logic [31:0] gpioA_i_ival, gpioA_o_oval, gpioA_o_oe, cmt_pc, x3_o;
  logic        jtag_tdo_oval, jtag_tdo_oe, cmt_valid;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int lf_div = 0;
  int lf_toggles = 0;
  bit lf_en = 1'b0;

  e203_soc_lite dut (
    .hfextclk(hfextclk), .rst(rst), .lfextclk(lfextclk),
    .ext_irq(ext_irq), .sft_irq(sft_irq), .tmr_irq(tmr_irq),
    .gpioA_i_ival(gpioA_i_ival), .gpioA_o_oval(gpioA_o_oval), .gpioA_o_oe(gpioA_o_oe),
    .jtag_tdo_oval(jtag_tdo_oval), .jtag_tdo_oe(jtag_tdo_oe),
    .cmt_valid(cmt_valid), .cmt_pc(cmt_pc), .x3_o(x3_o)
  );

  always #5 hfextclk = ~hfextclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance one cycle; also produces 4 lfextclk rises after enable
  task automatic tick();
    @(negedge hfextclk);
    cyc++;
    if (lf_en && lf_toggles < 8) begin
      lf_div++;
      if (lf_div == 3) begin
        lfextclk = ~lfextclk;
        lf_toggles++;
        lf_div = 0;
      end
    end
  endtask

  int last_at = 0;
  int gap = 0;

  task automatic expect_commit(input logic [31:0] exp_pc);
    bit seen;
    logic [31:0] got_pc;
    seen = 1'b0;
    got_pc = 32'd0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (cmt_valid === 1'b1) begin
        seen = 1'b1;
        got_pc = cmt_pc;
        break;
      end
    end
    check("commit_seen", {31'd0, seen}, 32'd1);
    check("cmt_pc", got_pc, exp_pc);
    gap = cyc - last_at;
    last_at = cyc;
  endtask

  task automatic put(input logic [31:0] addr, input logic [31:0] w);
    int idx;
    idx = int'((addr - 32'h8000_0000) >> 3);
    if (addr[2]) dut.mem_r[idx][63:32] = w;
    else         dut.mem_r[idx][31:0]  = w;
  endtask

  logic [31:0] prog [0:19] = '{
    32'hDEADC1B7, 32'hEEF18193, 32'h00019463, 32'h00000013, 32'h00001463,
    32'h800002B7, 32'h10028293, 32'h30529073, 32'h00800313, 32'h30032073,
    32'h0A500493, 32'h10012537, 32'h00952423, 32'h0FF00593, 32'h00B52223,
    32'h00052603, 32'h000601B3, 32'h0200C737, 32'hFF872183, 32'hFFFFFFFF
  };

  initial begin
    rst = 1'b1; lfextclk = 1'b0;
    ext_irq = 1'b0; sft_irq = 1'b0; tmr_irq = 1'b0;
    gpioA_i_ival = 32'h3C5A_1234;
    for (int i = 0; i < 20; i++) put(32'h8000_0000 + 32'(i * 4), prog[i]);
    put(32'h8000_0100, 32'h342023F3);
    put(32'h8000_0104, 32'h30002473);
    put(32'h8000_0108, 32'h30200073);

    // reset held three cycles
    tick(); tick(); tick();
    check("rst_cmt_valid", {31'd0, cmt_valid}, 32'd0);
    check("rst_x3", x3_o, 32'd0);
    check("rst_oval", gpioA_o_oval, 32'd0);
    check("rst_oe", gpioA_o_oe, 32'd0);
    check("rst_pc", dut.pc_r, 32'h8000_0000);
    check("jtag_tdo", {30'd0, jtag_tdo_oval, jtag_tdo_oe}, 32'd0);
    rst = 1'b0;
    lf_en = 1'b1;
    ext_irq = 1'b1;
    tmr_irq = 1'b1;
    last_at = cyc;

    // LUI/ADDI build 0xDEADBEEF, two cycles apart
    expect_commit(32'h8000_0000);
    check("first_latency", 32'(gap), 32'd2);
    expect_commit(32'h8000_0004);
    check("alu_gap", 32'(gap), 32'd2);
    check("x3_deadbeef", x3_o, 32'hDEAD_BEEF);

    // BNE taken skips 0x0C; BNE x0,x0 falls through
    expect_commit(32'h8000_0008);
    expect_commit(32'h8000_0010);
    expect_commit(32'h8000_0014);

    // mtvec=0x80000100, then MIE=1 with ext+tmr pending since reset release
    expect_commit(32'h8000_0018);
    expect_commit(32'h8000_001C);
    expect_commit(32'h8000_0020);
    expect_commit(32'h8000_0024);
    check("mie_set", {31'd0, dut.mie_r}, 32'd1);
    expect_commit(32'h8000_0100);
    check("irq_mcause", dut.mcause_r, 32'h8000_000B);
    check("irq_mepc", dut.mepc_r, 32'h8000_0028);
    check("irq_mie_clr", {31'd0, dut.mie_r}, 32'd0);
    ext_irq = 1'b0;
    tmr_irq = 1'b0;
    expect_commit(32'h8000_0104);
    expect_commit(32'h8000_0108);
    check("mret_mie", {31'd0, dut.mie_r}, 32'd1);
    check("x7_mcause", dut.rf_r[7], 32'h8000_000B);
    check("x8_mstatus", dut.rf_r[8], 32'h0000_0080);

    // GPIO stores and input load
    expect_commit(32'h8000_0028);
    expect_commit(32'h8000_002C);
    expect_commit(32'h8000_0030);
    check("sw_gap", 32'(gap), 32'd3);
    check("gpio_oval", gpioA_o_oval, 32'h0000_00A5);
    expect_commit(32'h8000_0034);
    expect_commit(32'h8000_0038);
    check("gpio_oe", gpioA_o_oe, 32'h0000_00FF);
    expect_commit(32'h8000_003C);
    expect_commit(32'h8000_0040);
    check("gpio_in_x3", x3_o, 32'h3C5A_1234);

    // mtime after four lfextclk rises
    expect_commit(32'h8000_0044);
    expect_commit(32'h8000_0048);
    check("mtime_x3", x3_o, 32'd4);

    // illegal word at 0x4C: no commit, trap to mtvec
    expect_commit(32'h8000_0100);
    check("ill_mcause", dut.mcause_r, 32'd2);
    check("ill_mepc", dut.mepc_r, 32'h8000_004C);
    check("ill_mie_clr", {31'd0, dut.mie_r}, 32'd0);

    // reset in the middle of an instruction
    tick();
    rst = 1'b1;
    tick();
    check("mid_rst_pc", dut.pc_r, 32'h8000_0000);
    check("mid_rst_x3", x3_o, 32'd0);
    check("mid_rst_oval", gpioA_o_oval, 32'd0);
    check("mid_rst_oe", gpioA_o_oe, 32'd0);
    check("mid_rst_mcause", dut.mcause_r, 32'd0);
    check("mid_rst_cmt", {31'd0, cmt_valid}, 32'd0);
    check("itcm_kept", dut.mem_r[0][31:0], 32'hDEADC1B7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
